// File: rtl/axi4_mem_slave.sv
// AXI4 memory slave: single-outstanding-transaction burst engine over a 64-bit word store.
// Write wins arbitration in IDLE. Out-of-range beats read as zero with SLVERR and are
// never written. WRAP bursts advance like INCR.
module axi4_mem_slave #(
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned MEM_BYTES      = 65536
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    // AR channel
    input  logic [AXI_ID_WIDTH-1:0]     arid_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   araddr_i,
    input  logic [7:0]                  arlen_i,
    input  logic [2:0]                  arsize_i,
    input  logic [1:0]                  arburst_i,
    input  logic                        arvalid_i,
    output logic                        arready_o,
    // R channel
    output logic [AXI_ID_WIDTH-1:0]     rid_o,
    output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]                  rresp_o,
    output logic                        rlast_o,
    output logic                        rvalid_o,
    input  logic                        rready_i,
    // AW channel
    input  logic [AXI_ID_WIDTH-1:0]     awid_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   awaddr_i,
    input  logic [7:0]                  awlen_i,
    input  logic [2:0]                  awsize_i,
    input  logic [1:0]                  awburst_i,
    input  logic                        awvalid_i,
    output logic                        awready_o,
    // W channel
    input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                        wlast_i,
    input  logic                        wvalid_i,
    output logic                        wready_o,
    // B channel
    output logic [AXI_ID_WIDTH-1:0]     bid_o,
    output logic [1:0]                  bresp_o,
    output logic                        bvalid_o,
    input  logic                        bready_i
);

    localparam int unsigned MemAw = $clog2(MEM_BYTES);
    localparam int unsigned Words = MEM_BYTES / 8;
    localparam int unsigned IdxW  = MemAw - 3;
    localparam int unsigned Lanes = AXI_DATA_WIDTH / 8;
    localparam logic [AXI_ADDR_WIDTH:0] MemLimit = (AXI_ADDR_WIDTH + 1)'(MEM_BYTES);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] BurstFixed = 2'b00;

    typedef enum logic [1:0] {StIdle, StRd, StWr, StWresp} state_e;

    state_e                    state_q, state_d;
    logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                len_q, len_d;
    logic [2:0]                size_q, size_d;
    logic [1:0]                burst_q, burst_d;
    logic [7:0]                beat_q, beat_d;
    logic                      err_q, err_d;

    logic [AXI_DATA_WIDTH-1:0] mem [Words];

    logic                      in_range;
    logic [IdxW-1:0]           word_idx;
    logic [1:0]                size_eff;
    logic [AXI_ADDR_WIDTH-1:0] addr_next;
    logic                      last_beat;
    logic                      mem_we;

    // Current-beat address decode and next-beat address
    always_comb begin
        in_range  = ({1'b0, addr_q} < MemLimit);
        word_idx  = addr_q[MemAw-1:3];
        size_eff  = (size_q > 3'd3) ? 2'd3 : size_q[1:0];
        addr_next = (burst_q == BurstFixed) ? addr_q
                                            : addr_q + (AXI_ADDR_WIDTH'(1) << size_eff);
        last_beat = (beat_q == len_q);
    end

    // Next-state, latch updates and channel outputs
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        err_d     = err_q;
        arready_o = 1'b0;
        awready_o = 1'b0;
        rvalid_o  = 1'b0;
        rid_o     = '0;
        rdata_o   = '0;
        rresp_o   = RespOkay;
        rlast_o   = 1'b0;
        wready_o  = 1'b0;
        bvalid_o  = 1'b0;
        bid_o     = '0;
        bresp_o   = RespOkay;
        mem_we    = 1'b0;

        case (state_q)
            StIdle: begin
                // Ready is held low while reset is applied so no handshake is implied.
                awready_o = !rst_i;
                arready_o = !rst_i && !awvalid_i;
                if (awvalid_i) begin
                    id_d    = awid_i;
                    addr_d  = awaddr_i;
                    len_d   = awlen_i;
                    size_d  = awsize_i;
                    burst_d = awburst_i;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = StWr;
                end else if (arvalid_i) begin
                    id_d    = arid_i;
                    addr_d  = araddr_i;
                    len_d   = arlen_i;
                    size_d  = arsize_i;
                    burst_d = arburst_i;
                    beat_d  = '0;
                    state_d = StRd;
                end
            end
            StRd: begin
                rvalid_o = 1'b1;
                rid_o    = id_q;
                rlast_o  = last_beat;
                if (in_range) begin
                    rdata_o = mem[word_idx];
                end else begin
                    rresp_o = RespSlverr;
                end
                if (rready_i) begin
                    addr_d = addr_next;
                    beat_d = beat_q + 8'd1;
                    if (last_beat) begin
                        state_d = StIdle;
                    end
                end
            end
            StWr: begin
                wready_o = 1'b1;
                if (wvalid_i) begin
                    mem_we = in_range && !rst_i;
                    if (!in_range || (wlast_i != last_beat)) begin
                        err_d = 1'b1;
                    end
                    addr_d = addr_next;
                    beat_d = beat_q + 8'd1;
                    // The beat count, not wlast, terminates the burst.
                    if (last_beat) begin
                        state_d = StWresp;
                    end
                end
            end
            StWresp: begin
                bvalid_o = 1'b1;
                bid_o    = id_q;
                bresp_o  = err_q ? RespSlverr : RespOkay;
                if (bready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM and transaction latches, synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    // Byte-lane writes into the backing store; contents survive reset
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int i = 0; i < Lanes; i++) begin
                if (wstrb_i[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Scoreboard bench for axi4_mem_slave: a byte-array model predicts every R beat and B
// response; a negedge monitor compares whatever the DUT presents against the queue heads.
module tb_axi4_mem_slave;

    localparam int unsigned IDW    = 4;
    localparam int unsigned TB_MEM = 65536;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  arid_i = '0;
    logic [31:0] araddr_i = '0;
    logic [7:0]  arlen_i = '0;
    logic [2:0]  arsize_i = '0;
    logic [1:0]  arburst_i = '0;
    logic        arvalid_i = 1'b0;
    logic        arready_o;
    logic [3:0]  rid_o;
    logic [63:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        rlast_o;
    logic        rvalid_o;
    logic        rready_i = 1'b0;
    logic [3:0]  awid_i = '0;
    logic [31:0] awaddr_i = '0;
    logic [7:0]  awlen_i = '0;
    logic [2:0]  awsize_i = '0;
    logic [1:0]  awburst_i = '0;
    logic        awvalid_i = 1'b0;
    logic        awready_o;
    logic [63:0] wdata_i = '0;
    logic [7:0]  wstrb_i = '0;
    logic        wlast_i = 1'b0;
    logic        wvalid_i = 1'b0;
    logic        wready_o;
    logic [3:0]  bid_o;
    logic [1:0]  bresp_o;
    logic        bvalid_o;
    logic        bready_i = 1'b0;

    axi4_mem_slave #(
        .AXI_ID_WIDTH   (IDW),
        .AXI_DATA_WIDTH (64),
        .AXI_ADDR_WIDTH (32),
        .MEM_BYTES      (TB_MEM)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .arid_i    (arid_i),
        .araddr_i  (araddr_i),
        .arlen_i   (arlen_i),
        .arsize_i  (arsize_i),
        .arburst_i (arburst_i),
        .arvalid_i (arvalid_i),
        .arready_o (arready_o),
        .rid_o     (rid_o),
        .rdata_o   (rdata_o),
        .rresp_o   (rresp_o),
        .rlast_o   (rlast_o),
        .rvalid_o  (rvalid_o),
        .rready_i  (rready_i),
        .awid_i    (awid_i),
        .awaddr_i  (awaddr_i),
        .awlen_i   (awlen_i),
        .awsize_i  (awsize_i),
        .awburst_i (awburst_i),
        .awvalid_i (awvalid_i),
        .awready_o (awready_o),
        .wdata_i   (wdata_i),
        .wstrb_i   (wstrb_i),
        .wlast_i   (wlast_i),
        .wvalid_i  (wvalid_i),
        .wready_o  (wready_o),
        .bid_o     (bid_o),
        .bresp_o   (bresp_o),
        .bvalid_o  (bvalid_o),
        .bready_i  (bready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rbeat_t      rq[$];
    bexp_t       bq[$];
    logic [7:0]  mdl [TB_MEM];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];
    bit          wl [256];
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Address of beat k from the burst parameters alone
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int k,
                                              input logic [2:0] size, input logic [1:0] burst);
        int unsigned sz = (size > 3'd3) ? 3 : int'(size);
        if (burst == 2'b00) return a;
        return a + 32'(k) * (32'd1 << sz);
    endfunction

    function automatic logic [63:0] model_word(input logic [31:0] ba);
        logic [63:0] w;
        int base = int'(ba) & ~7;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = mdl[base + i];
        return w;
    endfunction

    function automatic void fill_random(input int len, input bit full);
        for (int k = 0; k <= len; k++) begin
            wd[k] = {$urandom, $urandom};
            ws[k] = full ? 8'hFF : 8'($urandom);
        end
    endfunction

    // Apply the burst in wd/ws to the model and queue the expected B response.
    // bad selects a beat whose wlast is inverted (-1 for none).
    function automatic void prep_write(input logic [3:0] id, input logic [31:0] a, input int len,
                                       input logic [2:0] size, input logic [1:0] burst,
                                       input int bad);
        bit          err = 1'b0;
        logic [31:0] ba;
        int          base;
        bexp_t       e;
        for (int k = 0; k <= len; k++) begin
            wl[k] = (k == len) ^ (k == bad);
            if (k == bad) err = 1'b1;
            ba = beat_addr(a, k, size, burst);
            if (ba >= TB_MEM) begin
                err = 1'b1;
            end else begin
                base = int'(ba) & ~7;
                for (int i = 0; i < 8; i++)
                    if (ws[k][i]) mdl[base + i] = wd[k][8*i +: 8];
            end
        end
        e.id   = id;
        e.resp = err ? 2'b10 : 2'b00;
        bq.push_back(e);
    endfunction

    function automatic void prep_read(input logic [3:0] id, input logic [31:0] a, input int len,
                                      input logic [2:0] size, input logic [1:0] burst);
        rbeat_t      e;
        logic [31:0] ba;
        for (int k = 0; k <= len; k++) begin
            ba     = beat_addr(a, k, size, burst);
            e.id   = id;
            e.last = (k == len);
            if (ba >= TB_MEM) begin
                e.data = '0;
                e.resp = 2'b10;
            end else begin
                e.data = model_word(ba);
                e.resp = 2'b00;
            end
            rq.push_back(e);
        end
    endfunction

    task automatic aw_phase(input logic [3:0] id, input logic [31:0] a, input int len,
                            input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        bit hs = 1'b0;
        awid_i = id; awaddr_i = a; awlen_i = 8'(len); awsize_i = size; awburst_i = burst;
        awvalid_i = 1'b1;
        while (!hs && n < 300) begin
            @(negedge clk_i); hs = awready_o;
            @(posedge clk_i); #1; n++;
        end
        awvalid_i = 1'b0;
        check("aw_handshake", 64'(hs), 1);
    endtask

    task automatic w_phase(input int len);
        for (int k = 0; k <= len; k++) begin
            int n = 0;
            bit hs = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                wvalid_i = 1'b0;
                @(posedge clk_i); #1;
            end
            wvalid_i = 1'b1; wdata_i = wd[k]; wstrb_i = ws[k]; wlast_i = wl[k];
            while (!hs && n < 300) begin
                @(negedge clk_i); hs = wready_o;
                @(posedge clk_i); #1; n++;
            end
            if (!hs) begin
                check("w_handshake", 64'(hs), 1);
                break;
            end
        end
        wvalid_i = 1'b0;
        wlast_i  = 1'b0;
    endtask

    task automatic b_phase();
        int n = 0;
        bit hs = 1'b0;
        int dly = $urandom_range(0, 2);
        bready_i = (dly == 0);
        while (!hs && n < 300) begin
            @(negedge clk_i); hs = bvalid_o && bready_i;
            @(posedge clk_i); #1; n++;
            if (n >= dly) bready_i = 1'b1;
        end
        bready_i = 1'b0;
        check("b_handshake", 64'(hs), 1);
        check("b_leftover", 64'(bq.size()), 0);
    endtask

    // Drives AR until accepted; waits returns cycles spent before acceptance.
    task automatic ar_phase(input logic [3:0] id, input logic [31:0] a, input int len,
                            input logic [2:0] size, input logic [1:0] burst, output int waits);
        bit hs = 1'b0;
        arid_i = id; araddr_i = a; arlen_i = 8'(len); arsize_i = size; arburst_i = burst;
        arvalid_i = 1'b1;
        waits = 0;
        while (!hs && waits < 300) begin
            @(negedge clk_i); hs = arready_o;
            @(posedge clk_i); #1;
            if (!hs) waits++;
        end
        arvalid_i = 1'b0;
        check("ar_handshake", 64'(hs), 1);
        @(negedge clk_i);
        check("first_rvalid", 64'(rvalid_o), 1);
        @(posedge clk_i); #1;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random
    task automatic r_phase(input int mode);
        int c = 0;
        bit done = 1'b0;
        while (!done && c < 2000) begin
            case (mode)
                0:       rready_i = 1'b1;
                1:       rready_i = (c % 3 == 0);
                default: rready_i = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk_i); done = rvalid_o && rready_i && rlast_o;
            @(posedge clk_i); #1; c++;
        end
        rready_i = 1'b0;
        check("r_burst_done", 64'(done), 1);
        check("r_leftover", 64'(rq.size()), 0);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] a, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input int bad);
        prep_write(id, a, len, size, burst, bad);
        aw_phase(id, a, len, size, burst);
        w_phase(len);
        b_phase();
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] a, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode);
        int w;
        prep_read(id, a, len, size, burst);
        ar_phase(id, a, len, size, burst, w);
        r_phase(mode);
    endtask

    // Scoreboard monitor: every presented beat is compared, held or not
    always @(negedge clk_i) begin
        if (!rst_i && rvalid_o) begin
            check("r_awready_low", 64'(awready_o), 0);
            check("r_expected", 64'(rq.size() > 0), 1);
            if (rq.size() > 0) begin
                check("rid", 64'(rid_o), 64'(rq[0].id));
                check("rdata", rdata_o, rq[0].data);
                check("rresp", 64'(rresp_o), 64'(rq[0].resp));
                check("rlast", 64'(rlast_o), 64'(rq[0].last));
                if (rready_i) void'(rq.pop_front());
            end
        end
        if (!rst_i && bvalid_o) begin
            check("b_readies_low", 64'({arready_o, awready_o}), 0);
            check("b_expected", 64'(bq.size() > 0), 1);
            if (bq.size() > 0) begin
                check("bid", 64'(bid_o), 64'(bq[0].id));
                check("bresp", 64'(bresp_o), 64'(bq[0].resp));
                if (bready_i) void'(bq.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits;
        int hs_cnt;
        int n;

        // Reset values
        repeat (3) @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("rst_rvalid", 64'(rvalid_o), 0);
        check("rst_bvalid", 64'(bvalid_o), 0);
        check("rst_wready", 64'(wready_o), 0);
        check("rst_rlast", 64'(rlast_o), 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_ids", 64'({rid_o, bid_o}), 0);
        check("rst_resps", 64'({rresp_o, bresp_o}), 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("idle_arready", 64'(arready_o), 1);
        check("idle_awready", 64'(awready_o), 1);
        @(posedge clk_i); #1;

        // Known contents for the low window used by reads
        fill_random(127, 1'b1);
        do_write(4'h0, 32'h0, 127, 3'd3, 2'b01, -1);

        // Write/read line
        wd[0] = 64'h1111_1111_1111_1111; wd[1] = 64'h2222_2222_2222_2222;
        wd[2] = 64'h3333_3333_3333_3333; wd[3] = 64'h4444_4444_4444_4444;
        for (int k = 0; k < 4; k++) ws[k] = 8'hFF;
        do_write(4'h5, 32'h100, 3, 3'd3, 2'b01, -1);
        do_read(4'h2, 32'h100, 3, 3'd3, 2'b01, 0);

        // Byte strobes
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
        do_write(4'h1, 32'h200, 0, 3'd3, 2'b01, -1);
        wd[0] = 64'h0; ws[0] = 8'h0F;
        do_write(4'h1, 32'h200, 0, 3'd3, 2'b01, -1);
        do_read(4'h4, 32'h200, 0, 3'd3, 2'b01, 0);

        // Backpressure
        do_read(4'h6, 32'h100, 3, 3'd3, 2'b01, 1);

        // Arbitration: AW and AR together
        fill_random(3, 1'b1);
        prep_write(4'h7, 32'h300, 3, 3'd3, 2'b01, -1);
        prep_read(4'h9, 32'h300, 3, 3'd3, 2'b01);
        awid_i = 4'h7; awaddr_i = 32'h300; awlen_i = 8'd3; awsize_i = 3'd3; awburst_i = 2'b01;
        arid_i = 4'h9; araddr_i = 32'h300; arlen_i = 8'd3; arsize_i = 3'd3; arburst_i = 2'b01;
        awvalid_i = 1'b1; arvalid_i = 1'b1;
        @(negedge clk_i);
        check("arb_awready", 64'(awready_o), 1);
        check("arb_arready", 64'(arready_o), 0);
        @(posedge clk_i); #1;
        awvalid_i = 1'b0;
        @(negedge clk_i);
        check("arb_arready_wr", 64'(arready_o), 0);
        @(posedge clk_i); #1;
        w_phase(3);
        b_phase();
        ar_phase(4'h9, 32'h300, 3, 3'd3, 2'b01, waits);
        check("arb_ar_first_idle", 64'(waits), 0);
        r_phase(0);

        // Errors and address boundaries
        do_read(4'h1, TB_MEM, 0, 3'd3, 2'b01, 0);
        fill_random(1, 1'b1);
        do_write(4'h2, 32'h180, 1, 3'd3, 2'b01, 0);
        fill_random(3, 1'b0);
        do_write(4'h3, TB_MEM - 16, 3, 3'd3, 2'b01, -1);
        do_read(4'h3, TB_MEM - 16, 3, 3'd3, 2'b01, 2);
        fill_random(0, 1'b1);
        do_write(4'h4, TB_MEM + 32'h100, 0, 3'd3, 2'b01, -1);
        do_read(4'h4, 32'h100, 0, 3'd3, 2'b01, 0);
        do_read(4'h5, 32'hFFFF_FFF8, 1, 3'd3, 2'b01, 0);
        do_read(4'h6, 32'h80, 3, 3'd6, 2'b10, 2);
        fill_random(2, 1'b0);
        do_write(4'h7, 32'h88, 2, 3'd3, 2'b00, -1);
        do_read(4'h8, 32'h80, 3, 3'd1, 2'b01, 0);
        do_read(4'h8, 32'h88, 2, 3'd3, 2'b00, 0);

        // Randomized mix inside the known window
        for (int t = 0; t < 40; t++) begin
            logic [3:0]  id    = 4'($urandom);
            logic [31:0] a     = 32'($urandom_range(0, 32'h37F));
            int          len   = $urandom_range(0, 15);
            logic [2:0]  size  = 3'($urandom);
            logic [1:0]  burst = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 0) begin
                fill_random(len, 1'($urandom_range(0, 1)));
                do_write(id, a, len, size, burst,
                         ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1);
            end else begin
                do_read(id, a, len, size, burst, $urandom_range(0, 2));
            end
        end

        // Reset during beat 2 of a 4-beat read
        prep_read(4'h3, 32'h40, 3, 3'd3, 2'b01);
        ar_phase(4'h3, 32'h40, 3, 3'd3, 2'b01, waits);
        rready_i = 1'b1;
        hs_cnt = 0;
        n = 0;
        while (hs_cnt < 2 && n < 100) begin
            @(negedge clk_i); if (rvalid_o && rready_i) hs_cnt++;
            @(posedge clk_i); #1; n++;
        end
        check("rst_beats_before", 64'(hs_cnt), 2);
        rready_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        rq.delete();
        @(negedge clk_i);
        check("midrst_rvalid", 64'(rvalid_o), 0);
        check("midrst_idle", 64'(arready_o), 1);
        check("midrst_rdata", rdata_o, 0);
        @(posedge clk_i); #1;
        do_read(4'hA, 32'h40, 3, 3'd3, 2'b01, 2);

        repeat (3) @(posedge clk_i);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi4_mem_slave.md
AXI4_MEM_SLAVE -- requirements
Module: axi4_mem_slave

Interface
REQ-001 Parameter AXI_ID_WIDTH, default 4: width of all ID fields.
REQ-002 Parameter AXI_DATA_WIDTH, default 64: data width; SHALL be 64 (8 byte lanes).
REQ-003 Parameter AXI_ADDR_WIDTH, default 32: address width.
REQ-004 Parameter MEM_BYTES, default 65536: backing-store size in bytes, power of two, multiple of 8.
REQ-005 Ports, name, direction, width, meaning. Clock and reset first.
- clk_i, in, 1: the single clock; all logic on its rising edge.
- rst_i, in, 1: reset, synchronous and active-high.
- AR: arid_i ID, araddr_i ADDR, arlen_i 8, arsize_i 3, arburst_i 2, arvalid_i 1 in; arready_o 1 out.
- R: rid_o ID, rdata_o 64, rresp_o 2, rlast_o 1, rvalid_o 1 out; rready_i 1 in.
- AW: awid_i ID, awaddr_i ADDR, awlen_i 8, awsize_i 3, awburst_i 2, awvalid_i 1 in; awready_o 1 out.
- W: wdata_i 64, wstrb_i 8, wlast_i 1, wvalid_i 1 in; wready_o 1 out.
- B: bid_o ID, bresp_o 2, bvalid_o 1 out; bready_i 1 in.
REQ-006 The block SHALL ignore arlock/arcache/arprot/arqos and the AW equivalents; these are not ports.

Function
REQ-007 Storage: MEM_BYTES/8 words of 64 bits; word index = addr[log2(MEM_BYTES)-1:3]; not cleared by reset.
REQ-008 FSM states: IDLE, RD, WR, WRESP; one transaction outstanding at a time.
REQ-009 In IDLE: awready_o=1; arready_o=!awvalid_i. This gives write priority when both valids are asserted.
REQ-010 AW handshake in IDLE: latch awid, awaddr, awlen, awsize, awburst; clear beat counter and error flag; go to WR.
REQ-011 AR handshake in IDLE: latch arid, araddr, arlen, arsize, arburst; clear beat counter; go to RD.
REQ-012 In RD: rvalid_o=1; rid_o=latched ID.
- rdata_o = full 64-bit word at the current address.
- rlast_o = (beat counter == latched len).
- First rvalid appears exactly 1 cycle after the AR handshake.
REQ-013 While rvalid_o && !rready_i, the block SHALL hold rdata_o, rresp_o, rlast_o and rid_o stable.
REQ-014 On R handshake: the beat counter and address advance. If rlast_o is set, the FSM goes to IDLE.
REQ-015 Address advance: burst FIXED (00) keeps the address. INCR (01) and WRAP (10, treated as INCR) add 2^size bytes. Arithmetic is AXI_ADDR_WIDTH bits, wrapping modulo 2^AXI_ADDR_WIDTH.
REQ-016 Latched size > 3 SHALL be treated as 3.
REQ-017 In WR: wready_o=1. On W handshake, each byte lane i with wstrb_i[i]=1 SHALL be written to the current word. The beat counter and address then advance per REQ-015.
REQ-018 WR ends on the handshake where the beat counter == latched len; the FSM goes to WRESP. wlast_i does not end the burst.
REQ-019 If wlast_i differs from (beat counter == len) on any W beat, the error flag SHALL be set.
REQ-020 Out of range is address ≥ MEM_BYTES.
- Read beat out of range: rdata_o=0, rresp_o=SLVERR (10); otherwise OKAY (00).
- Write beat out of range: the write is suppressed and the error flag is set.
REQ-021 In WRESP: bvalid_o=1; bid_o=latched ID; bresp_o = SLVERR if the error flag is set, else OKAY.
REQ-022 On B handshake, the FSM goes to IDLE. arready_o and awready_o are 0 in every state except IDLE.
REQ-023 Back-to-back: the cycle after a burst ends, the FSM is in IDLE and can accept a new request. The minimum gap between transactions is 1 cycle.

Reset
REQ-024 While rst_i=1 at a clock edge, the FSM SHALL go to IDLE and the counters, latches and error flag SHALL clear.
REQ-025 Reset output values: rvalid_o=0, bvalid_o=0, wready_o=0, rlast_o=0, rdata_o=0, rid_o=0, bid_o=0, rresp_o=0, bresp_o=0. arready_o/awready_o follow REQ-009 from the first cycle after reset.
REQ-026 Reset mid-burst SHALL abandon the burst without a response. Memory writes completed before reset SHALL persist.

Verification
REQ-027 Write/read line: AW addr 0x100, len 3, size 3, INCR, id 5; W data 0x11..,0x22..,0x33..,0x44.. with strb 0xFF. Required: bid 5, bresp OKAY. Then AR of the same burst with id 2 returns the four words in order, rlast on beat 3 only, rid 2.
REQ-028 Byte strobe: write 0xFFFF_FFFF_FFFF_FFFF to 0x200, then 0x0 with strb 0x0F. Required: a read of 0x200 returns 0xFFFF_FFFF_0000_0000.
REQ-029 Backpressure: a 4-beat read with rready toggling 1,0,0,1,... Required: data and rlast stay stable during stalls, no beat is lost, first rvalid 1 cycle after AR.
REQ-030 Arbitration: awvalid and arvalid raised in the same cycle. Required: AW handshake first with arready_o=0; AR is accepted in the first IDLE cycle after B.
REQ-031 Errors: read at MEM_BYTES returns rdata 0 with SLVERR. A write burst len 1 with wlast on beat 0 returns bresp SLVERR.
REQ-032 Reset mid-read: rst_i asserted during beat 2 of a 4-beat read. Required: rvalid_o=0 the next cycle, FSM in IDLE, a new read completes correctly.
